usb_sram_loader: RTL

- PC-to-memory download path: reads bytes from the FT245 RX FIFO (RXF/RD handshake), pairs them into 16-bit words, and writes them to the external async SRAM at consecutive addresses.
- Inverse of the SRAM-to-USB transfer (command #5), which sends each SRAM word low byte first, then high byte.
- Used to load reference waveforms into SRAM from the PC. Sits beside the command decoder; when BUSY=1 it owns the USB read strobe and the SRAM bus.

---
 rtl/usb_sram_loader.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/usb_sram_loader.sv
// -----------------------------------------------------------------------------
// usb_sram_loader
// Moves data from the PC into the external async SRAM. Bytes are read from the
// FT245 RX FIFO using the RXF/RD handshake. Each pair of bytes becomes one
// 16-bit word: the first byte is the low byte and the second is the high byte.
// Words are written to consecutive SRAM addresses starting at BASE_ADRS. This
// is the inverse of the SRAM-to-USB dump, which sends the low byte first.
//
// Optional feature macro: LOADER_CHECKSUM_EN. When it is defined, the o_csum
// port carries a modulo-2^16 sum of every word written.
//
// Ports
//   i_clk        system clock (125 MHz)
//   i_rstn       synchronous active-low reset
//   i_start      one-cycle pulse; begins a transfer when idle
//   i_abort      returns to idle on the next cycle; has priority over all
//   i_base_adrs  first SRAM word address
//   i_len        number of 16-bit words to load (0 = immediate DONE)
//   i_usbx       FT245 data bus
//   i_rxf        FT245 "RX data available", active low
//   o_rd         FT245 read strobe, active low
//   o_adx        SRAM word address
//   o_dx_out     SRAM write data
//   o_dx_oe      drive o_dx_out onto the SRAM bus
//   o_cex        SRAM OE_n
//   o_cey        SRAM WE_n
//   o_ce1/o_ce2  SRAM chip enables (tied active)
//   o_bhe/o_ble  SRAM byte enables (both lanes always written)
//   o_busy       transfer in progress
//   o_done       one-cycle pulse when the transfer completes
//   o_wcount     words written so far
//   o_csum       (LOADER_CHECKSUM_EN only) running sum of written words
// -----------------------------------------------------------------------------
module usb_sram_loader #(
  parameter int RD_LOW  = 5,
  parameter int RD_HIGH = 2,
  parameter int WE_LOW  = 2
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [19:0] i_base_adrs,
  input  logic [15:0] i_len,
  input  logic [7:0]  i_usbx,
  input  logic        i_rxf,
  output logic        o_rd,
  output logic [19:0] o_adx,
  output logic [15:0] o_dx_out,
  output logic        o_dx_oe,
  output logic        o_cex,
  output logic        o_cey,
  output logic        o_ce1,
  output logic        o_ce2,
  output logic        o_bhe,
  output logic        o_ble,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_wcount
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0] o_csum
`endif
);

  localparam logic [7:0] RD_LOW_LAST  = 8'(RD_LOW - 1);
  localparam logic [7:0] RD_HIGH_LAST = 8'(RD_HIGH - 1);
  localparam logic [7:0] WE_LOW_LAST  = 8'(WE_LOW - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WAIT_LO  = 4'd1,
    S_RD_LO    = 4'd2,
    S_PRE_LO   = 4'd3,
    S_WAIT_HI  = 4'd4,
    S_RD_HI    = 4'd5,
    S_WR_SETUP = 4'd6,
    S_WR_PULSE = 4'd7,
    S_WR_HOLD  = 4'd8,
    S_FINISH   = 4'd9
  } state_t;

  // The checksum wraps modulo 2^16.
  function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [15:0] word);
    csum_add = acc + word;
  endfunction

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [7:0]  r_lo;
  logic [15:0] r_len;
  logic        r_rd;
  logic [19:0] r_adx;
  logic [15:0] r_dx_out;
  logic        r_dx_oe;
  logic        r_cex;
  logic        r_cey;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_wcount;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] r_csum;
`endif

  logic [15:0] w_wcount_inc;
  logic [19:0] w_adx_inc;

  // The 20-bit add wraps 0xFFFFF to 0x00000 naturally.
  assign w_wcount_inc = r_wcount + 16'd1;
  assign w_adx_inc    = r_adx + 20'd1;

  // Transfer state machine. All outputs are registered and are set when the
  // machine enters the state that owns them.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_lo     <= 8'd0;
      r_len    <= 16'd0;
      r_rd     <= 1'b1;
      r_adx    <= 20'd0;
      r_dx_out <= 16'd0;
      r_dx_oe  <= 1'b0;
      r_cex    <= 1'b0;
      r_cey    <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wcount <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
      r_csum   <= 16'd0;
`endif
    end else if (i_abort) begin
      // Release both buses at once. Completed words stay counted, and any
      // partial word is dropped.
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_rd    <= 1'b1;
      r_cey   <= 1'b1;
      r_dx_oe <= 1'b0;
      r_cex   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_adx    <= i_base_adrs;
            r_len    <= i_len;
            r_wcount <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
            r_csum   <= 16'd0;
`endif
            if (i_len == 16'd0) begin
              r_done <= 1'b1;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_WAIT_LO;
            end
          end
        end
        S_WAIT_LO: begin
          if (!i_rxf) begin
            r_rd    <= 1'b0;
            r_cnt   <= 8'd0;
            r_state <= S_RD_LO;
          end
        end
        S_RD_LO: begin
          if (r_cnt == RD_LOW_LAST) begin
            r_lo    <= i_usbx;
            r_rd    <= 1'b1;
            r_cnt   <= 8'd0;
            r_state <= S_PRE_LO;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_PRE_LO: begin
          if (r_cnt == RD_HIGH_LAST) begin
            r_cnt   <= 8'd0;
            r_state <= S_WAIT_HI;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WAIT_HI: begin
          if (!i_rxf) begin
            r_rd    <= 1'b0;
            r_cnt   <= 8'd0;
            r_state <= S_RD_HI;
          end
        end
        S_RD_HI: begin
          // The precharge after the high byte overlaps the SRAM write.
          // SETUP + PULSE + HOLD + WAIT_LO always spans at least RD_HIGH
          // cycles, so RD stays high long enough without extra states.
          if (r_cnt == RD_LOW_LAST) begin
            r_rd     <= 1'b1;
            r_dx_out <= {i_usbx, r_lo};
            r_cex    <= 1'b1;
            r_dx_oe  <= 1'b1;
            r_cey    <= 1'b1;
            r_cnt    <= 8'd0;
            r_state  <= S_WR_SETUP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WR_SETUP: begin
          r_cey   <= 1'b0;
          r_cnt   <= 8'd0;
          r_state <= S_WR_PULSE;
        end
        S_WR_PULSE: begin
          if (r_cnt == WE_LOW_LAST) begin
            r_cey   <= 1'b1;
            r_cnt   <= 8'd0;
            r_state <= S_WR_HOLD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WR_HOLD: begin
          // Data stays driven through the hold cycle. The bus is released
          // on exit, so the data drive never outlives OE_n being high.
          r_adx    <= w_adx_inc;
          r_wcount <= w_wcount_inc;
`ifdef LOADER_CHECKSUM_EN
          r_csum   <= csum_add(r_csum, r_dx_out);
`endif
          r_dx_oe  <= 1'b0;
          r_cex    <= 1'b0;
          if (w_wcount_inc == r_len) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_state <= S_WAIT_LO;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_rd    <= 1'b1;
          r_cey   <= 1'b1;
          r_dx_oe <= 1'b0;
          r_cex   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_rd     = r_rd;
  assign o_adx    = r_adx;
  assign o_dx_out = r_dx_out;
  assign o_dx_oe  = r_dx_oe;
  assign o_cex    = r_cex;
  assign o_cey    = r_cey;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_wcount = r_wcount;
  assign o_ce1    = 1'b0;
  assign o_ce2    = 1'b1;
  assign o_bhe    = 1'b0;
  assign o_ble    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
  assign o_csum   = r_csum;
`endif

endmodule
